// File: rtl/uart_rx_if.sv
// Receive-side bundle for the 9N1 serial receiver: the serial line plus the
// valid/ack word handoff and the error flags.
interface uart_rx_if;
    logic       rx;
    logic [8:0] data;
    logic       data_valid;
    logic       data_ack;
    logic       framing_error;
    logic       overrun;

    modport master (
        input  rx,
        input  data_ack,
        output data,
        output data_valid,
        output framing_error,
        output overrun
    );

    modport slave (
        output rx,
        output data_ack,
        input  data,
        input  data_valid,
        input  framing_error,
        input  overrun
    );
endinterface

// File: rtl/uart_rx.sv
// 9N1 serial receiver: oversampled rx, start/stop validation, valid/ack holding register.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling around each mid-bit point.
module uart_rx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic     clock,
    input  logic     reset_n,
    uart_rx_if.master bus
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_TC = CW'(CLKS_PER_BIT - 1);
`ifdef UART_RX_MAJORITY_EN
    localparam logic [CW-1:0] START_TC = CW'(CLKS_PER_BIT / 2);
`else
    localparam logic [CW-1:0] START_TC = CW'(CLKS_PER_BIT / 2 - 1);
`endif

    // state | meaning: IDLE line idle | START verify start at mid-bit | DATA shift 9 bits
    //                  STOP check stop bit | WAIT_HIGH line stuck low after a framing error
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    idx_q, idx_d;
    logic [8:0]    shift_q, shift_d;
    logic          done_q, done_d;
    logic          ok_q, ok_d;
    logic          rx_m, rx_s;
    logic          sample;
    logic [8:0]    data_q;
    logic          valid_q, ferr_q, ovr_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= bus.rx;
            rx_s <= rx_m;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    // Decision at mid+1 votes over rx_s at mid-1, mid and mid+1.
    logic [1:0] rx_hist;
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) rx_hist <= 2'b11;
        else          rx_hist <= {rx_hist[0], rx_s};
    end
    assign sample = (rx_hist[1] & rx_hist[0]) | (rx_hist[1] & rx_s) | (rx_hist[0] & rx_s);
`else
    assign sample = rx_s;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            done_q  <= 1'b0;
            ok_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            done_q  <= done_d;
            ok_q    <= ok_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        shift_d = shift_q;
        done_d  = 1'b0;
        ok_d    = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx_s) state_d = START;
            end
            START: begin
                if (cnt_q == START_TC) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = sample ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == BIT_TC) begin
                    cnt_d   = '0;
                    shift_d = {sample, shift_q[8:1]};
                    if (idx_q == 4'd8) state_d = STOP;
                    else               idx_d   = idx_q + 4'd1;
                end
            end
            STOP: begin
                if (cnt_q == BIT_TC) begin
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    ok_d    = sample;
                    state_d = sample ? IDLE : WAIT_HIGH;
                end
            end
            WAIT_HIGH: begin
                cnt_d = '0;
                if (rx_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Frame verdict is registered, so the holding register updates one edge after the stop sample.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            ferr_q <= done_q & ~ok_q;
            if (valid_q && bus.data_ack) ovr_q <= 1'b0;
            if (done_q && ok_q) begin
                if (!valid_q || bus.data_ack) begin
                    data_q  <= shift_q;
                    valid_q <= 1'b1;
                end else begin
                    ovr_q <= 1'b1;
                end
            end else if (valid_q && bus.data_ack) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.data          = data_q;
    assign bus.data_valid    = valid_q;
    assign bus.framing_error = ferr_q;
    assign bus.overrun       = ovr_q;
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit: vector table of single frames
// plus hand-written sequences for timing, back-to-back, break, false start, overrun, reset.
module tb_uart_rx;
    localparam int CPB = 16;

    logic clock = 1'b0;
    logic reset_n;
    uart_rx_if bus ();

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int mark = 0;
    int rise_cyc = 0;
    int fe_cnt = 0;
    logic dv_prev = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (bus.data_valid && !dv_prev) rise_cyc = cyc;
        if (bus.framing_error) fe_cnt = fe_cnt + 1;
        dv_prev = bus.data_valid;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [8:0] word;
        logic       stop_bit;
        logic       exp_valid;
        logic [8:0] exp_data;
        int         exp_fe;
    } vec_t;

    vec_t       vecs[6];
    logic [8:0] got_w[3];
    bit         got_ok[3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // Call at a negedge; returns at a negedge with rx left at the stop level.
    task automatic send_frame(input logic [8:0] w, input logic stop_val, input int stop_cyc);
        bus.rx = 1'b0;
        mark = cyc;
        repeat (CPB) @(negedge clock);
        for (int i = 0; i < 9; i++) begin
            bus.rx = w[i];
            repeat (CPB) @(negedge clock);
        end
        bus.rx = stop_val;
        repeat (stop_cyc) @(negedge clock);
    endtask

    task automatic ack_once();
        bus.data_ack = 1'b1;
        @(negedge clock);
        bus.data_ack = 1'b0;
    endtask

    task automatic take_word(output logic [8:0] w, output bit got);
        got = 1'b0;
        w = '0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clock);
            if (bus.data_valid) begin
                got = 1'b1;
                w = bus.data;
                ack_once();
            end
        end
    endtask

    initial begin
        int fe_base;
        logic [8:0] w;

        vecs[0] = '{9'h155, 1'b1, 1'b1, 9'h155, 0};
        vecs[1] = '{9'h000, 1'b1, 1'b1, 9'h000, 0};
        vecs[2] = '{9'h1FF, 1'b1, 1'b1, 9'h1FF, 0};
        vecs[3] = '{9'h0F0, 1'b0, 1'b0, 9'h000, 1};
        vecs[4] = '{9'h123, 1'b1, 1'b1, 9'h123, 0};
        vecs[5] = '{9'h0A5, 1'b1, 1'b1, 9'h0A5, 0};

        reset_n = 1'b0;
        bus.rx = 1'b1;
        bus.data_ack = 1'b0;
        repeat (3) @(negedge clock);
        check("reset_data", 32'(bus.data), 32'h0);
        check("reset_valid", 32'(bus.data_valid), 32'h0);
        check("reset_ferr", 32'(bus.framing_error), 32'h0);
        check("reset_ovr", 32'(bus.overrun), 32'h0);
        reset_n = 1'b1;
        repeat (4) @(negedge clock);

        // single frame timing: rx falls, 3 edges to t0, valid at t0+169
        fe_base = fe_cnt;
        send_frame(9'h155, 1'b1, CPB);
        repeat (4) @(negedge clock);
        check("t_rise_latency", 32'(rise_cyc - mark), 32'd172);
        check("t_data", 32'(bus.data), 32'h155);
        check("t_valid", 32'(bus.data_valid), 32'h1);
        check("t_ferr_cnt", 32'(fe_cnt - fe_base), 32'h0);
        check("t_ovr", 32'(bus.overrun), 32'h0);
        ack_once();
        check("t_valid_after_ack", 32'(bus.data_valid), 32'h0);

        // ack with nothing valid is ignored
        bus.data_ack = 1'b1;
        repeat (3) @(negedge clock);
        bus.data_ack = 1'b0;
        check("idle_ack_valid", 32'(bus.data_valid), 32'h0);
        check("idle_ack_ovr", 32'(bus.overrun), 32'h0);

        for (int k = 0; k < 6; k++) begin
            fe_base = fe_cnt;
            send_frame(vecs[k].word, vecs[k].stop_bit, CPB);
            bus.rx = 1'b1;
            repeat (6) @(negedge clock);
            check($sformatf("vec%0d_valid", k), 32'(bus.data_valid), 32'(vecs[k].exp_valid));
            check($sformatf("vec%0d_fe", k), 32'(fe_cnt - fe_base), 32'(vecs[k].exp_fe));
            check($sformatf("vec%0d_ovr", k), 32'(bus.overrun), 32'h0);
            if (vecs[k].exp_valid) begin
                check($sformatf("vec%0d_data", k), 32'(bus.data), 32'(vecs[k].exp_data));
                ack_once();
                check($sformatf("vec%0d_ack", k), 32'(bus.data_valid), 32'h0);
            end
        end

        // back-to-back frames, consumer acks as soon as valid is seen
        fork
            begin
                send_frame(9'h1FF, 1'b1, CPB);
                send_frame(9'h000, 1'b1, CPB);
                send_frame(9'h0A5, 1'b1, CPB);
            end
            begin
                for (int k = 0; k < 3; k++) take_word(got_w[k], got_ok[k]);
            end
        join
        check("b2b_got0", 32'(got_ok[0]), 32'h1);
        check("b2b_word0", 32'(got_w[0]), 32'h1FF);
        check("b2b_got1", 32'(got_ok[1]), 32'h1);
        check("b2b_word1", 32'(got_w[1]), 32'h000);
        check("b2b_got2", 32'(got_ok[2]), 32'h1);
        check("b2b_word2", 32'(got_w[2]), 32'h0A5);
        check("b2b_ovr", 32'(bus.overrun), 32'h0);
        repeat (10) @(negedge clock);

        // break: stop bit low and line held low for 40 bit times
        fe_base = fe_cnt;
        send_frame(9'h0F0, 1'b0, 40 * CPB);
        bus.rx = 1'b1;
        repeat (10) @(negedge clock);
        check("brk_fe_pulses", 32'(fe_cnt - fe_base), 32'h1);
        check("brk_valid", 32'(bus.data_valid), 32'h0);
        send_frame(9'h123, 1'b1, CPB);
        repeat (4) @(negedge clock);
        check("brk_next_valid", 32'(bus.data_valid), 32'h1);
        check("brk_next_data", 32'(bus.data), 32'h123);
        ack_once();

        // false start: 4 low cycles
        fe_base = fe_cnt;
        bus.rx = 1'b0;
        repeat (4) @(negedge clock);
        bus.rx = 1'b1;
        repeat (40) @(negedge clock);
        check("fs_valid", 32'(bus.data_valid), 32'h0);
        check("fs_fe", 32'(fe_cnt - fe_base), 32'h0);
        send_frame(9'h001, 1'b1, CPB);
        repeat (4) @(negedge clock);
        check("fs_next_valid", 32'(bus.data_valid), 32'h1);
        check("fs_next_data", 32'(bus.data), 32'h001);
        ack_once();

        // overrun: second frame arrives with no ack
        send_frame(9'h011, 1'b1, CPB);
        send_frame(9'h022, 1'b1, CPB);
        repeat (4) @(negedge clock);
        check("ovr_data", 32'(bus.data), 32'h011);
        check("ovr_flag", 32'(bus.overrun), 32'h1);
        check("ovr_valid", 32'(bus.data_valid), 32'h1);
        ack_once();
        check("ovr_clear", 32'(bus.overrun), 32'h0);
        check("ovr_valid_clear", 32'(bus.data_valid), 32'h0);

        // reset in the middle of data bit 4 with a word pending
        send_frame(9'h0A5, 1'b1, CPB);
        repeat (4) @(negedge clock);
        check("rst_pre_valid", 32'(bus.data_valid), 32'h1);
        w = 9'h1AA;
        fe_base = fe_cnt;
        bus.rx = 1'b0;
        repeat (CPB) @(negedge clock);
        for (int i = 0; i < 4; i++) begin
            bus.rx = w[i];
            repeat (CPB) @(negedge clock);
        end
        bus.rx = w[4];
        repeat (CPB / 2) @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        check("rst_async_data", 32'(bus.data), 32'h0);
        check("rst_async_valid", 32'(bus.data_valid), 32'h0);
        check("rst_async_ovr", 32'(bus.overrun), 32'h0);
        check("rst_async_fe", 32'(bus.framing_error), 32'h0);
        bus.rx = 1'b1;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        repeat (20 * CPB) @(negedge clock);
        check("rst_no_fe", 32'(fe_cnt - fe_base), 32'h0);
        check("rst_no_valid", 32'(bus.data_valid), 32'h0);
        send_frame(9'h1AA, 1'b1, CPB);
        repeat (4) @(negedge clock);
        check("rst_next_valid", 32'(bus.data_valid), 32'h1);
        check("rst_next_data", 32'(bus.data), 32'h1AA);
        ack_once();
        check("rst_next_ack", 32'(bus.data_valid), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
